// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b computed LSB first, one bit per clock,
// with a start/busy/done handshake and a held result/borrow.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit step per edge, WIDTH steps total
// DONE  | single-cycle result pulse; start here launches the next op
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  sif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic d_bit;
    logic br_n;

    assign d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_n  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE, DONE: begin
                if (sif.start) begin
                    sa_d    = sif.a;
                    sb_d    = sif.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {d_bit, sr_q[WIDTH-1:1]};
                br_d  = br_n;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the assembled result directly from this step.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {d_bit, sr_q[WIDTH-1:1]};
                    bout_d  = br_n;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign sif.busy = (state_q == RUN);
    assign sif.done = (state_q == DONE);
    assign sif.diff = diff_q;
    assign sif.bout = bout_q;
endmodule
